// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-wide data memory that stalls the CPU via BUSYWAIT for a fixed access latency
module data_mem_ctrl #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int ACCESS_CYCLES = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);
  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              accept, last, mem_we;
  always_comb begin
    accept   = state_q == IDLE && (READ ^ WRITE);
    last     = state_q == ACCESS && cnt_q == '0;
    mem_we   = last && wr_q;
    state_d  = accept ? ACCESS : state_q == ACCESS ? (last ? DONE : ACCESS) : IDLE;
    cnt_d    = accept ? CNT_W'(ACCESS_CYCLES - 1) : (state_q == ACCESS && !last) ? cnt_q - CNT_W'(1) : cnt_q;
    wr_d     = accept ? WRITE : wr_q;
    addr_d   = accept ? ADDRESS : addr_q;
    wdata_d  = accept ? WRITEDATA : wdata_q;
    rdata_d  = (last && !wr_q) ? mem[addr_q] : rdata_q;
    BUSYWAIT = RESET && (state_q == ACCESS || accept);
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end
  always_ff @(posedge CLK) begin
    if (RESET && mem_we) mem[addr_q] <= wdata_q;
  end
  assign READDATA = rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl latency, data and reset behaviour
module tb_data_mem_ctrl;
  localparam int AC = 5;
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       READ = 1'b0;
  logic       WRITE = 1'b0;
  logic [7:0] ADDRESS = 8'h00;
  logic [7:0] WRITEDATA = 8'h00;
  logic [7:0] READDATA;
  logic       BUSYWAIT;
  logic [7:0] mem_m [256];
  logic [7:0] rd_m = 8'h00;
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .ACCESS_CYCLES(AC)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );
  task automatic req(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic perturb);
    int n = 0;
    READ = !wr;
    WRITE = wr;
    ADDRESS = a;
    WRITEDATA = d;
    if (!wr) exp_q.push_back(mem_m[a]);
    #1;
    while (BUSYWAIT && n < 50) begin
      n++;
      @(posedge CLK);
      #1;
      if (perturb && n == 1) begin
        ADDRESS = a ^ 8'h30;
        WRITEDATA = ~d;
        READ = 1'b0;
        WRITE = 1'b0;
      end
    end
    checks++;
    if (n !== AC + 1) begin
      errors++;
      $display("FAIL stall_len op=%0d addr=%h: busy %0d cycles, expected %0d", wr, a, n, AC + 1);
    end
    if (wr) mem_m[a] = d;
    else if (exp_q.size() > 0) rd_m = exp_q.pop_front();
    checks++;
    if (READDATA !== rd_m) begin
      errors++;
      $display("FAIL readdata op=%0d addr=%h: got %h, expected %h", wr, a, READDATA, rd_m);
    end
    READ = 1'b0;
    WRITE = 1'b0;
  endtask
  task automatic idle();
    @(posedge CLK);
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, expected 0", BUSYWAIT);
    end
  endtask
  task automatic test_reset();
    RESET = 1'b0;
    READ = 1'b1;
    ADDRESS = 8'h00;
    repeat (2) begin
      @(posedge CLK);
      #1;
      checks++;
      if (BUSYWAIT !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy: got %b, expected 0", BUSYWAIT);
      end
    end
    checks++;
    if (READDATA !== 8'h00) begin
      errors++;
      $display("FAIL reset_readdata: got %h, expected 00", READDATA);
    end
    READ = 1'b0;
    RESET = 1'b1;
    idle();
  endtask
  task automatic test_store_load();
    req(1'b1, 8'h1A, 8'h5C, 1'b0);
    idle();
    req(1'b0, 8'h1A, 8'h00, 1'b0);
    idle();
  endtask
  task automatic test_input_hold();
    req(1'b1, 8'h10, 8'h3C, 1'b0);
    idle();
    req(1'b1, 8'h20, 8'hC3, 1'b0);
    idle();
    req(1'b0, 8'h10, 8'h00, 1'b1);
    idle();
    req(1'b1, 8'h55, 8'h99, 1'b1);
    idle();
    req(1'b0, 8'h55, 8'h00, 1'b0);
    idle();
  endtask
  task automatic test_illegal();
    req(1'b1, 8'h00, 8'h81, 1'b0);
    idle();
    READ = 1'b1;
    WRITE = 1'b1;
    ADDRESS = 8'h00;
    WRITEDATA = 8'hFF;
    repeat (3) begin
      #1;
      checks++;
      if (BUSYWAIT !== 1'b0) begin
        errors++;
        $display("FAIL illegal_busy: got %b, expected 0", BUSYWAIT);
      end
      @(posedge CLK);
      #1;
    end
    READ = 1'b0;
    WRITE = 1'b0;
    idle();
    req(1'b0, 8'h00, 8'h00, 1'b0);
    idle();
  endtask
  task automatic test_reset_mid_write();
    req(1'b1, 8'h40, 8'h77, 1'b0);
    idle();
    WRITE = 1'b1;
    ADDRESS = 8'h40;
    WRITEDATA = 8'h33;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    WRITE = 1'b0;
    RESET = 1'b0;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b, expected 0", BUSYWAIT);
    end
    @(posedge CLK);
    #1;
    rd_m = 8'h00;
    checks++;
    if (READDATA !== 8'h00) begin
      errors++;
      $display("FAIL abort_readdata: got %h, expected 00", READDATA);
    end
    RESET = 1'b1;
    idle();
    req(1'b0, 8'h40, 8'h00, 1'b0);
    idle();
  endtask
  task automatic test_back_to_back();
    req(1'b1, 8'hFF, 8'hA5, 1'b0);
    idle();
    req(1'b0, 8'hFF, 8'h00, 1'b0);
    idle();
    req(1'b1, 8'hFF, 8'h5A, 1'b0);
    idle();
    req(1'b0, 8'hFF, 8'h00, 1'b0);
    idle();
    req(1'b0, 8'h1A, 8'h00, 1'b0);
    idle();
  endtask
  initial begin
    test_reset();
    test_store_load();
    test_input_hold();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
